// File: rtl/adder_nbits_pipeline_if.sv
// Operand/result handshake bundle for adder_nbits_pipeline.
// The ovf signal exists only when ADDER_PIPE_OVF_EN is defined.
interface adder_nbits_pipeline_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             co;
`ifdef ADDER_PIPE_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, y, co, ovf
    );

    modport slave (
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, y, co, ovf
    );
`else
    modport master (
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, y, co
    );

    modport slave (
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, y, co
    );
`endif
endinterface

// File: rtl/adder_nbits_pipeline.sv
// WIDTH-bit adder split into SEG-bit carry segments, one segment per pipeline stage, with valid/ready backpressure.
// Defining ADDER_PIPE_OVF_EN adds a registered signed-overflow flag (ovf) held alongside y.
module adder_nbits_pipeline #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input logic                   clk,
    input logic                   resetn,
    adder_nbits_pipeline_if.slave bus
);
    localparam int N   = (SEG > 0) ? WIDTH / SEG : 1;
    localparam int REM = (SEG > 0) ? WIDTH % SEG : 1;

    if (SEG < 1 || SEG > WIDTH || REM != 0) begin : g_bad_cfg
        $error("adder_nbits_pipeline: WIDTH must be a non-zero multiple of SEG");
    end

    logic stall;

    // A waiting result freezes every stage, bubbles included.
    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;

    for (genvar k = 0; k < N; k++) begin : g_stage
        // AW: operand bits still to be added on entry; YW: result bits complete on exit.
        localparam int AW = WIDTH - k * SEG;
        localparam int YW = (k + 1) * SEG;

        logic          v_in;
        logic          c_in;
        logic [AW-1:0] a_in;
        logic [AW-1:0] b_in;
        logic [YW-1:0] y_nxt;
        logic [SEG:0]  sum;
        logic          v_q;
        logic          c_q;
        logic [YW-1:0] y_q;

        assign sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

        if (k == 0) begin : g_src
            assign v_in  = bus.in_valid;
            assign c_in  = bus.ci;
            assign a_in  = bus.a;
            assign b_in  = bus.b;
            assign y_nxt = sum[SEG-1:0];
        end else begin : g_src
            assign v_in  = g_stage[k-1].v_q;
            assign c_in  = g_stage[k-1].c_q;
            assign a_in  = g_stage[k-1].g_skew.a_q;
            assign b_in  = g_stage[k-1].g_skew.b_q;
            assign y_nxt = {sum[SEG-1:0], g_stage[k-1].y_q};
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                y_q <= '0;
            end else if (!stall) begin
                v_q <= v_in;
                c_q <= sum[SEG];
                y_q <= y_nxt;
            end
        end

        // Operand segments not yet added travel forward unchanged.
        if (k < N - 1) begin : g_skew
            logic [AW-SEG-1:0] a_q;
            logic [AW-SEG-1:0] b_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_in[AW-1:SEG];
                    b_q <= b_in[AW-1:SEG];
                end
            end
        end

`ifdef ADDER_PIPE_OVF_EN
        if (k == N - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    ovf_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q <= (a_in[AW-1] == b_in[AW-1]) && (sum[SEG-1] != a_in[AW-1]);
                end
            end
        end
`endif
    end

    assign bus.out_valid = g_stage[N-1].v_q;
    assign bus.y         = g_stage[N-1].y_q;
    assign bus.co        = g_stage[N-1].c_q;
`ifdef ADDER_PIPE_OVF_EN
    assign bus.ovf       = g_stage[N-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_adder_nbits_pipeline.sv
// Directed bench for adder_nbits_pipeline: a 16-bit and a 32-bit instance, both with SEG=8.
// The ovf checks are built only when ADDER_PIPE_OVF_EN is defined.
module tb_adder_nbits_pipeline;
    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    adder_nbits_pipeline_if #(.WIDTH(16)) bus16 ();
    adder_nbits_pipeline_if #(.WIDTH(32)) bus32 ();

    adder_nbits_pipeline #(.WIDTH(16), .SEG(8)) dut16 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus16.slave)
    );

    adder_nbits_pipeline #(.WIDTH(32), .SEG(8)) dut32 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus32.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn          = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.ci        = 1'b0;
        bus16.out_ready = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.a         = '0;
        bus32.b         = '0;
        bus32.ci        = 1'b0;
        bus32.out_ready = 1'b1;
        #12;
        checks++;
        if (bus16.out_valid !== 1'b0 || bus16.y !== 16'h0000 || bus16.co !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset16 got v=%b y=%h co=%b want v=0 y=0000 co=0", bus16.out_valid, bus16.y, bus16.co);
        end
        checks++;
        if (bus32.out_valid !== 1'b0 || bus32.y !== 32'h0 || bus32.co !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset32 got v=%b y=%h co=%b want v=0 y=0 co=0", bus32.out_valid, bus32.y, bus32.co);
        end
`ifdef ADDER_PIPE_OVF_EN
        checks++;
        if (bus16.ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ovf got %b want 0", bus16.ovf);
        end
`endif
        resetn = 1'b1;
        step();
        checks++;
        if (bus16.in_ready !== 1'b1 || bus32.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_reset got %b/%b want 1/1", bus16.in_ready, bus32.in_ready);
        end
    endtask

    task automatic test_carry16();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic        vc [3];
        logic [15:0] ey [3];
        logic        ec [3];
        va = '{16'h00FF, 16'hFFFF, 16'hFFFF};
        vb = '{16'h0001, 16'h0000, 16'hFFFF};
        vc = '{1'b0, 1'b1, 1'b1};
        ey = '{16'h0100, 16'h0000, 16'hFFFF};
        ec = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            bus16.in_valid = 1'b1;
            bus16.a        = va[i];
            bus16.b        = vb[i];
            bus16.ci       = vc[i];
            step();
            bus16.in_valid = 1'b0;
            checks++;
            if (bus16.out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL carry16_early[%0d] got out_valid=%b want 0", i, bus16.out_valid);
            end
            step();
            checks++;
            if (bus16.out_valid !== 1'b1 || bus16.y !== ey[i] || bus16.co !== ec[i]) begin
                errors++;
                $display("[TB] FAIL carry16[%0d] got v=%b y=%h co=%b want v=1 y=%h co=%b",
                         i, bus16.out_valid, bus16.y, bus16.co, ey[i], ec[i]);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [100];
        logic [31:0] tb_b [100];
        logic        tc [100];
        logic [32:0] texp [100];
        int          out_idx;
        out_idx = 0;
        for (int i = 0; i < 100; i++) begin
            ta[i]   = $urandom;
            tb_b[i] = $urandom;
            tc[i]   = 1'($urandom_range(0, 1));
            texp[i] = {1'b0, ta[i]} + {1'b0, tb_b[i]} + 33'(tc[i]);
        end
        bus32.out_ready = 1'b1;
        for (int t = 0; t < 110; t++) begin
            if (t < 100) begin
                bus32.in_valid = 1'b1;
                bus32.a        = ta[t];
                bus32.b        = tb_b[t];
                bus32.ci       = tc[t];
            end else begin
                bus32.in_valid = 1'b0;
            end
            step();
            if (bus32.out_valid === 1'b1) begin
                checks++;
                if (out_idx >= 100) begin
                    errors++;
                    $display("[TB] FAIL b2b_extra got result at edge %0d want none", t);
                end else if ({bus32.co, bus32.y} !== texp[out_idx] || t != out_idx + 3) begin
                    errors++;
                    $display("[TB] FAIL b2b[%0d] got %h at edge %0d want %h at edge %0d",
                             out_idx, {bus32.co, bus32.y}, t, texp[out_idx], out_idx + 3);
                end
                out_idx++;
            end
        end
        checks++;
        if (out_idx != 100) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d want 100", out_idx);
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] q [$];
        logic [32:0] pending;
        int          seen;
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus32.in_valid = 1'b1;
            bus32.a        = $urandom;
            bus32.b        = $urandom;
            bus32.ci       = i[0];
            q.push_back({1'b0, bus32.a} + {1'b0, bus32.b} + 33'(bus32.ci));
            step();
        end
        checks++;
        if (bus32.out_valid !== 1'b1 || {bus32.co, bus32.y} !== q[0]) begin
            errors++;
            $display("[TB] FAIL bp_full got v=%b %h want v=1 %h", bus32.out_valid, {bus32.co, bus32.y}, q[0]);
        end
        bus32.a         = 32'hFFFF_FFFF;
        bus32.b         = 32'h0000_0001;
        bus32.ci        = 1'b1;
        pending         = 33'h1_0000_0001;
        bus32.out_ready = 1'b0;
        #1;
        checks++;
        if (bus32.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_in_ready got %b want 0", bus32.in_ready);
        end
        repeat (5) begin
            step();
            checks++;
            if (bus32.out_valid !== 1'b1 || {bus32.co, bus32.y} !== q[0] || bus32.in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold got v=%b %h rdy=%b want v=1 %h rdy=0",
                         bus32.out_valid, {bus32.co, bus32.y}, bus32.in_ready, q[0]);
            end
        end
        q.push_back(pending);
        bus32.out_ready = 1'b1;
        #1;
        checks++;
        if (bus32.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release_ready got %b want 1", bus32.in_ready);
        end
        seen = 0;
        for (int t = 0; t < 12; t++) begin
            if (bus32.out_valid === 1'b1 && q.size() > 0) begin
                void'(q.pop_front());
                seen++;
            end
            step();
            bus32.in_valid = 1'b0;
            if (bus32.out_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL bp_dup got %h want no result", {bus32.co, bus32.y});
                end else if ({bus32.co, bus32.y} !== q[0]) begin
                    errors++;
                    $display("[TB] FAIL bp_drain got %h want %h", {bus32.co, bus32.y}, q[0]);
                end
            end
        end
        checks++;
        if (seen != 5 || q.size() != 0) begin
            errors++;
            $display("[TB] FAIL bp_count got %0d drained %0d left want 5 drained 0 left", seen, q.size());
        end
    endtask

    task automatic test_reset_midflight();
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus32.in_valid = 1'b1;
            bus32.a        = 32'h0101_0101 * (i + 1);
            bus32.b        = 32'h00FF_00FF;
            bus32.ci       = 1'b0;
            step();
        end
        bus32.in_valid = 1'b0;
        checks++;
        if (bus32.out_valid !== 1'b1 || bus32.y !== 32'h0200_0200) begin
            errors++;
            $display("[TB] FAIL rst_pre got v=%b y=%h want v=1 y=02000200", bus32.out_valid, bus32.y);
        end
        #3;
        resetn = 1'b0;
        #1;
        checks++;
        if (bus32.out_valid !== 1'b0 || bus32.y !== 32'h0 || bus32.co !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_async got v=%b y=%h co=%b want v=0 y=0 co=0", bus32.out_valid, bus32.y, bus32.co);
        end
        #2;
        resetn = 1'b1;
        for (int t = 0; t < 8; t++) begin
            step();
            checks++;
            if (bus32.out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rst_stale[%0d] got out_valid=%b y=%h want 0", t, bus32.out_valid, bus32.y);
            end
        end
    endtask

`ifdef ADDER_PIPE_OVF_EN
    task automatic test_ovf();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [15:0] ey [3];
        logic        ec [3];
        logic        eo [3];
        va = '{16'h7FFF, 16'h8000, 16'h0001};
        vb = '{16'h0001, 16'hFFFF, 16'hFFFF};
        ey = '{16'h8000, 16'h7FFF, 16'h0000};
        ec = '{1'b0, 1'b1, 1'b1};
        eo = '{1'b1, 1'b1, 1'b0};
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus16.in_valid = 1'b1;
            bus16.a        = va[i];
            bus16.b        = vb[i];
            bus16.ci       = 1'b0;
            step();
            bus16.in_valid = 1'b0;
            step();
            checks++;
            if (bus16.out_valid !== 1'b1 || bus16.y !== ey[i] || bus16.co !== ec[i] || bus16.ovf !== eo[i]) begin
                errors++;
                $display("[TB] FAIL ovf[%0d] got v=%b y=%h co=%b ovf=%b want v=1 y=%h co=%b ovf=%b",
                         i, bus16.out_valid, bus16.y, bus16.co, bus16.ovf, ey[i], ec[i], eo[i]);
            end
        end
        step();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_carry16();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
`ifdef ADDER_PIPE_OVF_EN
        test_ovf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
